// File: rtl/ptr_pkg.sv
// Shared opcode encoding and helpers for the pointer bank.
package ptr_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP       = 3'd0,
        OP_READ      = 3'd1,
        OP_WRITE     = 3'd2,
        OP_INC       = 3'd3,
        OP_DEC       = 3'd4,
        OP_READ_INC  = 3'd5,
        OP_DEC_READ  = 3'd6,
        OP_SET_LIMIT = 3'd7
    } ptr_op_e;

    // A zero step field is shorthand for a unit step.
    function automatic logic [31:0] eff_step(input logic [31:0] step);
        return (step == 32'd0) ? 32'd1 : step;
    endfunction

endpackage

// File: rtl/ptr_step_unit.sv
// Modulo (limit+1) add/subtract shared by every pointer in the bank.
module ptr_step_unit #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] lim,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap,
    output logic             step_err
);

    logic [WIDTH:0] p_x;
    logic [WIDTH:0] l_x;
    logic [WIDTH:0] l1;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] nxt_x;
    logic           unused_msb;

    assign p_x        = {1'b0, p};
    assign l_x        = {1'b0, lim};
    assign l1         = l_x + (WIDTH+1)'(1);
    assign step_err   = s > l1;
    assign nxt        = nxt_x[WIDTH-1:0];
    assign unused_msb = nxt_x[WIDTH];

    always_comb begin
        sum   = p_x + s;
        nxt_x = '0;
        wrap  = 1'b0;
        if (!dir) begin
            if (sum > l_x) begin
                nxt_x = sum - l1;
                wrap  = 1'b1;
            end else begin
                nxt_x = sum;
            end
        end else begin
            // p <= L keeps p + L + 1 inside WIDTH+1 bits
            if (p_x < s) begin
                nxt_x = p_x + l1 - s;
                wrap  = 1'b1;
            end else begin
                nxt_x = p_x - s;
            end
        end
    end

endmodule

// File: rtl/pointer_bank.sv
// Bank of wrapping address pointers with a backpressured read-result channel.
module pointer_bank
    import ptr_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int NUM_PTRS = 4,
    parameter int IDX_W    = (NUM_PTRS > 1) ? $clog2(NUM_PTRS) : 1,
    parameter int STEP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [IDX_W-1:0]  sel,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STEP_W-1:0] step_in,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              wrap,
    output logic              err
);

    logic [WIDTH-1:0] ptr_q [NUM_PTRS];
    logic [WIDTH-1:0] ptr_d [NUM_PTRS];
    logic [WIDTH-1:0] lim_q [NUM_PTRS];
    logic [WIDTH-1:0] lim_d [NUM_PTRS];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    ptr_op_e          op_e;
    logic             accept;
    logic             sel_ok;
    logic [WIDTH-1:0] cur_p, cur_l;
    logic [WIDTH-1:0] new_p, new_l;
    logic             ptr_we, lim_we;
    logic [WIDTH:0]   s_eff;
    logic             dir;
    logic [WIDTH-1:0] su_nxt;
    logic             su_wrap, su_err;

    assign op_ready = !(rd_valid_q && !rd_ready);
    assign accept   = op_valid && op_ready;
    assign op_e     = ptr_op_e'(op);
    assign s_eff    = (WIDTH+1)'(eff_step(32'(step_in)));
    assign dir      = (op_e == OP_DEC) || (op_e == OP_DEC_READ);

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wrap     = wrap_q;
    assign err      = err_q;

    // Out-of-range selects fall through with sel_ok low and zeroed values.
    always_comb begin
        sel_ok = 1'b0;
        cur_p  = '0;
        cur_l  = '0;
        for (int i = 0; i < NUM_PTRS; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_ok = 1'b1;
                cur_p  = ptr_q[i];
                cur_l  = lim_q[i];
            end
        end
    end

    ptr_step_unit #(.WIDTH(WIDTH)) u_step (
        .p        (cur_p),
        .s        (s_eff),
        .lim      (cur_l),
        .dir      (dir),
        .nxt      (su_nxt),
        .wrap     (su_wrap),
        .step_err (su_err)
    );

    always_comb begin
        new_p      = cur_p;
        new_l      = cur_l;
        ptr_we     = 1'b0;
        lim_we     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q && !rd_ready;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        if (accept) begin
            unique case (op_e)
                OP_NOP: ;
                OP_READ: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = cur_p;
                    err_d      = !sel_ok;
                end
                OP_WRITE: begin
                    if (!sel_ok || data_in > cur_l) begin
                        err_d = 1'b1;
                    end else begin
                        new_p  = data_in;
                        ptr_we = 1'b1;
                    end
                end
                OP_INC, OP_DEC, OP_READ_INC: begin
                    if (op_e == OP_READ_INC) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = cur_p;
                    end
                    if (!sel_ok || su_err) begin
                        err_d = 1'b1;
                    end else begin
                        new_p  = su_nxt;
                        ptr_we = 1'b1;
                        wrap_d = su_wrap;
                    end
                end
                OP_DEC_READ: begin
                    rd_valid_d = 1'b1;
                    if (!sel_ok || su_err) begin
                        err_d     = 1'b1;
                        rd_data_d = cur_p;
                    end else begin
                        rd_data_d = su_nxt;
                        new_p     = su_nxt;
                        ptr_we    = 1'b1;
                        wrap_d    = su_wrap;
                    end
                end
                OP_SET_LIMIT: begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else begin
                        new_l  = data_in;
                        lim_we = 1'b1;
                        if (cur_p > data_in) begin
                            new_p  = '0;
                            ptr_we = 1'b1;
                        end
                    end
                end
            endcase
        end
        for (int i = 0; i < NUM_PTRS; i++) begin
            ptr_d[i] = (ptr_we && sel == IDX_W'(i)) ? new_p : ptr_q[i];
            lim_d[i] = (lim_we && sel == IDX_W'(i)) ? new_l : lim_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PTRS; i++) begin
                ptr_q[i] <= '0;
                lim_q[i] <= '1;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PTRS; i++) begin
                ptr_q[i] <= ptr_d[i];
                lim_q[i] <= lim_d[i];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_pointer_bank.sv
// Scoreboarded bench for pointer_bank: reads push expected data, monitor pops.
module tb_pointer_bank;
    import ptr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op = 3'd0;
    logic [1:0]  sel = 2'd0;
    logic [19:0] data_in = '0;
    logic [3:0]  step_in = '0;
    logic [19:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        wrap;
    logic        err;

    int checks = 0;
    int passed = 0;
    logic [19:0] sb [$];

    pointer_bank dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .sel      (sel),
        .data_in  (data_in),
        .step_in  (step_in),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // Result is consumed at the next rising edge when valid and ready.
    always @(negedge clk) begin : monitor
        logic [19:0] e;
        if (reset && rd_valid && rd_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL rd_unexpected: got %h, want no result", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e)
                    $display("FAIL rd_data: got %h, want %h", rd_data, e);
                else
                    passed++;
            end
        end
    end

    // Returns #1 after the accepting edge.
    task automatic do_op(input ptr_op_e o, input int s, input logic [19:0] d,
                         input logic [3:0] st, input logic rd,
                         input logic [19:0] exp);
        int n;
        op       = o;
        sel      = 2'(s);
        data_in  = d;
        step_in  = st;
        op_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (op_ready) break;
            n++;
            if (n > 20) break;
        end
        if (n > 20) begin
            checks++;
            $display("FAIL op_accept: got stalled, want accept");
            op_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (rd) sb.push_back(exp);
        #1;
        op_valid = 1'b0;
        op       = OP_NOP;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rd_valid, wrap, err, op_ready} !== 4'b0001 || rd_data !== '0)
            $display("FAIL reset_outs: got v%b w%b e%b r%b d%h, want 0001 d0",
                     rd_valid, wrap, err, op_ready, rd_data);
        else passed++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_op(OP_READ, 2, '0, 0, 1'b1, 20'h00000);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 20'h0 || wrap !== 1'b0 || err !== 1'b0)
            $display("FAIL first_read: got v%b d%h w%b e%b, want v1 d0 w0 e0",
                     rd_valid, rd_data, wrap, err);
        else passed++;
        drain();
    endtask

    task automatic test_inc_wrap();
        do_op(OP_WRITE, 1, 20'hFFFFE, 0, 1'b0, '0);
        checks++;
        if (wrap !== 1'b0 || err !== 1'b0)
            $display("FAIL write_pulses: got w%b e%b, want w0 e0", wrap, err);
        else passed++;
        do_op(OP_INC, 1, '0, 4'd3, 1'b0, '0);
        checks++;
        if (wrap !== 1'b1 || err !== 1'b0)
            $display("FAIL inc_wrap: got w%b e%b, want w1 e0", wrap, err);
        else passed++;
        do_op(OP_READ, 1, '0, 0, 1'b1, 20'h00001);
        checks++;
        if (wrap !== 1'b0)
            $display("FAIL wrap_one_cycle: got %b, want 0", wrap);
        else passed++;
        drain();
    endtask

    task automatic test_stack();
        do_op(OP_SET_LIMIT, 0, 20'd9, 0, 1'b0, '0);
        do_op(OP_WRITE, 0, 20'd8, 0, 1'b0, '0);
        checks++;
        if (err !== 1'b0)
            $display("FAIL write_at_limit: got e%b, want e0", err);
        else passed++;
        do_op(OP_READ_INC, 0, '0, 4'd2, 1'b1, 20'd8);
        checks++;
        if (wrap !== 1'b1)
            $display("FAIL read_inc_wrap: got %b, want 1", wrap);
        else passed++;
        do_op(OP_DEC_READ, 0, '0, 4'd1, 1'b1, 20'd9);
        checks++;
        if (wrap !== 1'b1)
            $display("FAIL dec_read_wrap: got %b, want 1", wrap);
        else passed++;
        do_op(OP_DEC, 0, '0, 4'd0, 1'b0, '0);
        checks++;
        if (wrap !== 1'b0 || err !== 1'b0)
            $display("FAIL dec_step0: got w%b e%b, want w0 e0", wrap, err);
        else passed++;
        do_op(OP_READ, 0, '0, 0, 1'b1, 20'd8);
        drain();
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b0;
        do_op(OP_READ, 3, '0, 0, 1'b1, 20'd0);
        checks++;
        if (op_ready !== 1'b0 || rd_valid !== 1'b1)
            $display("FAIL bp_stall: got r%b v%b, want r0 v1", op_ready, rd_valid);
        else passed++;
        fork
            do_op(OP_INC, 3, '0, 4'd5, 1'b0, '0);
            begin
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (op_ready !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 20'd0)
                    $display("FAIL bp_hold: got r%b v%b d%h, want r0 v1 d0",
                             op_ready, rd_valid, rd_data);
                else passed++;
                rd_ready = 1'b1;
            end
        join
        checks++;
        if (rd_valid !== 1'b0)
            $display("FAIL bp_release: got v%b, want v0", rd_valid);
        else passed++;
        do_op(OP_READ, 3, '0, 0, 1'b1, 20'd5);
        drain();
    endtask

    task automatic test_errors();
        do_op(OP_SET_LIMIT, 3, 20'd15, 0, 1'b0, '0);
        do_op(OP_WRITE, 3, 20'd20, 0, 1'b0, '0);
        checks++;
        if (err !== 1'b1 || wrap !== 1'b0)
            $display("FAIL write_over_limit: got e%b w%b, want e1 w0", err, wrap);
        else passed++;
        do_op(OP_NOP, 3, '0, 0, 1'b0, '0);
        checks++;
        if (err !== 1'b0)
            $display("FAIL nop_no_pulse: got e%b, want e0", err);
        else passed++;
        do_op(OP_READ, 3, '0, 0, 1'b1, 20'd5);
        do_op(OP_WRITE, 3, 20'd7, 0, 1'b0, '0);
        do_op(OP_SET_LIMIT, 3, 20'd4, 0, 1'b0, '0);
        checks++;
        if (err !== 1'b0)
            $display("FAIL shrink_limit: got e%b, want e0", err);
        else passed++;
        do_op(OP_READ, 3, '0, 0, 1'b1, 20'd0);
        do_op(OP_WRITE, 3, 20'd2, 0, 1'b0, '0);
        do_op(OP_INC, 3, '0, 4'd6, 1'b0, '0);
        checks++;
        if (err !== 1'b1)
            $display("FAIL inc_big_step: got e%b, want e1", err);
        else passed++;
        do_op(OP_READ_INC, 3, '0, 4'd6, 1'b1, 20'd2);
        checks++;
        if (err !== 1'b1)
            $display("FAIL read_inc_big_step: got e%b, want e1", err);
        else passed++;
        do_op(OP_DEC_READ, 3, '0, 4'd6, 1'b1, 20'd2);
        checks++;
        if (err !== 1'b1 || wrap !== 1'b0)
            $display("FAIL dec_read_big_step: got e%b w%b, want e1 w0", err, wrap);
        else passed++;
        do_op(OP_INC, 3, '0, 4'd5, 1'b0, '0);
        checks++;
        if (err !== 1'b0 || wrap !== 1'b1)
            $display("FAIL inc_full_step: got e%b w%b, want e0 w1", err, wrap);
        else passed++;
        do_op(OP_READ, 3, '0, 0, 1'b1, 20'd2);
        drain();
    endtask

    task automatic test_back_to_back();
        do_op(OP_WRITE, 2, 20'd100, 0, 1'b0, '0);
        do_op(OP_READ_INC, 2, '0, 4'd4, 1'b1, 20'd100);
        do_op(OP_READ_INC, 2, '0, 4'd4, 1'b1, 20'd104);
        do_op(OP_DEC_READ, 2, '0, 4'd8, 1'b1, 20'd100);
        checks++;
        if (rd_valid !== 1'b1 || wrap !== 1'b0)
            $display("FAIL b2b_valid: got v%b w%b, want v1 w0", rd_valid, wrap);
        else passed++;
        do_op(OP_READ, 2, '0, 0, 1'b1, 20'd100);
        drain();
    endtask

    task automatic test_async_reset();
        rd_ready = 1'b0;
        do_op(OP_READ, 1, '0, 0, 1'b1, 20'd1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || op_ready !== 1'b1)
            $display("FAIL async_reset: got v%b r%b, want v0 r1", rd_valid, op_ready);
        else passed++;
        sb.delete();
        rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            do_op(OP_READ, i, '0, 0, 1'b1, 20'd0);
            do_op(OP_DEC_READ, i, '0, 4'd1, 1'b1, 20'hFFFFF);
            checks++;
            if (wrap !== 1'b1 || err !== 1'b0)
                $display("FAIL reset_limit_%0d: got w%b e%b, want w1 e0", i, wrap, err);
            else passed++;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_stack();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pointer_bank.md
Name: pointer_bank

Overview:
- Parametrised bank of NUM_PTRS independent address pointers, each WIDTH bits wide.
- Each pointer supports load, read, increment and decrement by a variable step. Increment and decrement wrap modulo a per-pointer limit.
- Combined read-and-modify ops (post-increment read, pre-decrement read) support stack and queue addressing.
- Sits beside the register file and feeds memory addressing. Reads return through a valid/ready result channel with backpressure.

Parameters:
- WIDTH, 20, pointer and data width.
- NUM_PTRS, 4, number of pointers.
- IDX_W, $clog2(NUM_PTRS) (min 1), width of the pointer select.
- STEP_W, 4, width of the step input.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- op_valid  input  1  op request.
- op_ready  output  1  bank can accept an op this cycle.
- op  input  3  opcode:
  - 0 NOP, 1 READ, 2 WRITE, 3 INC, 4 DEC
  - 5 READ_INC (return old value, then increment)
  - 6 DEC_READ (decrement, return new value)
  - 7 SET_LIMIT
- sel  input  IDX_W  pointer index.
- data_in  input  WIDTH  load value for WRITE, new limit for SET_LIMIT.
- step_in  input  STEP_W  step for INC/DEC/READ_INC/DEC_READ; 0 means 1.
- rd_data  output  WIDTH  read result.
- rd_valid  output  1  rd_data valid.
- rd_ready  input  1  consumer accepts rd_data.
- wrap  output  1  one-cycle pulse: the last accepted op wrapped a pointer.
- err  output  1  one-cycle pulse: the last accepted op was rejected.

Behaviour:
- Async reset (reset=0):
  - all pointers 0; all limits all-ones (2^WIDTH-1)
  - rd_data 0, rd_valid 0, wrap 0, err 0
  - any pending result is discarded.
- Handshake:
  - op accepted when op_valid && op_ready.
  - op_ready = !(rd_valid && !rd_ready). This is combinational and never depends on op_valid.
  - One op per cycle. Pointer state updates on the accepting edge, so an op in cycle N sees the update from cycle N-1.
- Read result:
  - Accepted READ, READ_INC or DEC_READ loads rd_data and sets rd_valid on the accepting edge. Latency is 1 cycle.
  - rd_data/rd_valid hold until rd_ready=1.
  - If the result is consumed and a new read is accepted in the same cycle, rd_valid stays 1 with the new data.
  - Otherwise rd_valid clears after a consumed cycle.
- Arithmetic (s = step_in==0 ? 1 : step_in; L = limit[sel]; work in WIDTH+1 bits):
  - INC: n = p + s. If n > L then p' = n - (L+1) and wrap pulse; else p' = n.
  - DEC: if p < s then p' = p + (L+1) - s and wrap pulse; else p' = p - s.
  - Results are defined for s <= L+1 and p <= L. Both invariants are maintained by the rules below.
- WRITE:
  - data_in <= L: load the pointer.
  - else: pointer unchanged and err pulse.
- SET_LIMIT:
  - limit[sel] = data_in.
  - If the current pointer > data_in, the pointer is cleared to 0 (no err).
- Step larger than L+1 on INC/DEC: op rejected, pointer unchanged, err pulse.
  - For READ_INC and DEC_READ with the same illegal step: the read still returns the current value and err pulses.
- sel >= NUM_PTRS (non-power-of-2 NUM_PTRS):
  - no state change, err pulse.
  - read ops return rd_data 0 with rd_valid 1.
- wrap and err are registered. They are high for exactly the cycle after the accepting edge, then return to 0.
- NOP is accepted with no effect on any state or pulse.
- Reset asserted while rd_valid is held: rd_valid drops immediately and the op is lost.

Decomposition:
- Package ptr_pkg holds:
  - opcode enum ptr_op_e (8 values above)
  - constant OP_W=3
  - helper function for effective step.
- Sub-module ptr_step_unit: combinational modulo add/sub of (p, s, L, dir) returning the next value, wrap and step_err.
  - One instance is shared by all pointers, since only one op executes per cycle.
- Top module holds the pointer and limit arrays, the result register and the handshake.

Test Plan:
- Reset release, READ sel=2, rd_ready=1 -> next cycle rd_valid=1, rd_data=0x00000; wrap=0, err=0.
- WRITE sel=1 0xFFFFE; INC sel=1 step 3 -> ptr1=0x00001, wrap pulse 1 cycle; READ returns 0x00001.
- SET_LIMIT sel=0 9; WRITE sel=0 8; READ_INC step 2 -> rd_data=8, ptr0=0, wrap. Then DEC_READ step 1 -> rd_data=9, wrap.
- Backpressure: READ sel=3 with rd_ready=0 -> op_ready=0; a following INC stalls with no ptr change. Raise rd_ready -> INC accepted same cycle, rd_valid clears next cycle.
- Errors with limit 15 on sel=3:
  - WRITE 20 -> err, ptr unchanged.
  - ptr=7, SET_LIMIT 4 -> ptr3=0, no err.
  - INC step 6 with limit 4 -> err, ptr unchanged.
- Async reset asserted mid-cycle while rd_valid held -> rd_valid=0 immediately. All pointers read 0 and all limits are 0xFFFFF after release.
